// File: rtl/mdu_pkg.sv
// Shared op codes, op-class decode and default latencies for the multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_DIV  = 2'd2,
        CLS_MOVE = 2'd3
    } op_class_e;

    // Reserved codes 11-15 fall into CLS_NONE and behave like NOP.
    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
            OP_DIV, OP_DIVU:                                        cls = CLS_DIV;
            OP_MTHI, OP_MTLO:                                       cls = CLS_MOVE;
            default:                                                cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider with MIPS-style sign and special-case fix-ups.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] safe_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;

    always_comb begin
        div_by_zero = (divisor == '0);
        neg_a       = is_signed & dividend[WIDTH-1];
        neg_b       = is_signed & divisor[WIDTH-1];
        mag_a       = neg_a ? (~dividend + 1'b1) : dividend;
        mag_b       = neg_b ? (~divisor + 1'b1) : divisor;
        // Substitute 1 for a zero divisor; the result is discarded upstream anyway.
        safe_b      = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        uq          = mag_a / safe_b;
        ur          = mag_a % safe_b;
        quotient    = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
        remainder   = neg_a ? (~ur + 1'b1) : ur;

        if (is_signed && (dividend == MOST_NEG) && (divisor == '1)) begin
            quotient  = dividend;
            remainder = '0;
        end
        if (div_by_zero) begin
            quotient  = '0;
            remainder = '0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: ops resolve at acceptance, HI/LO commit when busy drops.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output mdu_state_e       state_dbg
);

    if ((MULT_CYCLES < 1) || (MULT_CYCLES > 15)) begin : g_bad_mult_cycles
        $fatal(1, "mul_div_unit: MULT_CYCLES must be in 1..15");
    end
    if ((DIV_CYCLES < 1) || (DIV_CYCLES > 15)) begin : g_bad_div_cycles
        $fatal(1, "mul_div_unit: DIV_CYCLES must be in 1..15");
    end

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic               accept;
    op_class_e          cls;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mac;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               div_zero;

    mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .dividend    (a),
        .divisor     (b),
        .is_signed   (op == OP_DIV),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_zero)
    );

    // Sign- or zero-extend to 2*WIDTH so one truncated multiply covers both signednesses.
    always_comb begin
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        ext_a      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        product    = ext_a * ext_b;
        case (op)
            OP_MADD, OP_MADDU: mac = {hi_q, lo_q} + product;
            OP_MSUB, OP_MSUBU: mac = {hi_q, lo_q} - product;
            default:           mac = product;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cls       = op_class(op);
        accept    = start && !flush && (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cls)
                        CLS_MUL: begin
                            state_d   = ST_BUSY;
                            busy_d    = 1'b1;
                            cnt_d     = MULT_CNT;
                            pend_hi_d = mac[2*WIDTH-1:WIDTH];
                            pend_lo_d = mac[WIDTH-1:0];
                            pend_wr_d = 1'b1;
                        end
                        CLS_DIV: begin
                            state_d   = ST_BUSY;
                            busy_d    = 1'b1;
                            cnt_d     = DIV_CNT;
                            pend_hi_d = div_r;
                            pend_lo_d = div_q;
                            pend_wr_d = !div_zero;
                        end
                        CLS_MOVE: begin
                            if (op == OP_MTHI) hi_d = a;
                            else               lo_d = a;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    mdu_state_e   state_dbg;

    mul_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / bookkeeping
    always #5 clk = ~clk;

    int edge_idx = 0;
    always @(posedge clk) edge_idx++;

    int errors = 0;
    int checks = 0;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model: {hi,lo} as one 64-bit accumulator
    logic [63:0] m_acc = '0;
    int          busy_until = 0;

    function automatic logic [63:0] model_result(input logic [3:0] mop, input logic [31:0] ma,
                                                 input logic [31:0] mb, input logic [63:0] acc);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        logic [63:0] r;
        sa = ma;
        sb = mb;
        sp = longint'(sa) * longint'(sb);
        up = {32'b0, ma} * {32'b0, mb};
        case (mop)
            4'd1:  r = sp;
            4'd2:  r = up;
            4'd7:  r = acc + sp;
            4'd8:  r = acc + up;
            4'd9:  r = acc - sp;
            4'd10: r = acc - up;
            4'd3: begin
                if (mb == 0) r = acc;
                else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) r = {32'h0, ma};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4:  r = (mb == 0) ? acc : {ma % mb, ma / mb};
            4'd5:  r = {ma, acc[31:0]};
            4'd6:  r = {acc[63:32], ma};
            default: r = acc;
        endcase
        return r;
    endfunction

    function automatic int model_latency(input logic [3:0] mop);
        case (mop)
            4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: return 5;
            4'd3, 4'd4:                          return 10;
            default:                             return 0;
        endcase
    endfunction

    // Entry: {old_hi, old_lo, new_hi, new_lo, busy_cycles[7:0]}
    logic [135:0] exp_q[$];

    // ---------------- driver tasks (called just after a negedge)
    task automatic issue(input logic [3:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ifl);
        int          e;
        int          lat;
        logic [63:0] nxt;
        e     = edge_idx + 1;
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        flush = ifl;
        @(posedge clk);
        if (e > busy_until) begin
            lat = ifl ? 0 : model_latency(iop);
            nxt = ifl ? m_acc : model_result(iop, ia, ib, m_acc);
            exp_q.push_back({m_acc, nxt, 8'(lat)});
            m_acc      = nxt;
            busy_until = e + lat;
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !mon_active) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (done == 0) begin
            errors++;
            $display("FAIL wait_idle: got pending=%0d expected pending=0 within 200 cycles", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard
    logic         mon_active = 1'b0;
    logic [135:0] cur;
    int           busy_seen;

    always @(negedge clk) begin
        if (!mon_active && exp_q.size() > 0) begin
            cur        = exp_q[0];
            mon_active = 1'b1;
            busy_seen  = 0;
        end
        if (mon_active) begin
            if (busy) begin
                busy_seen++;
                check("hold_hi", hi, cur[135:104]);
                check("hold_lo", lo, cur[103:72]);
                if (busy_seen > 20) begin
                    check("busy_timeout", 32'(busy_seen), 32'(cur[7:0]));
                    void'(exp_q.pop_front());
                    mon_active = 1'b0;
                end
            end else begin
                check("busy_len", 32'(busy_seen), 32'(cur[7:0]));
                check("res_hi", hi, cur[71:40]);
                check("res_lo", lo, cur[39:8]);
                void'(exp_q.pop_front());
                mon_active = 1'b0;
            end
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus
    initial begin
        reset = 1'b1;
        idle(3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        reset      = 1'b0;
        m_acc      = '0;
        busy_until = edge_idx;

        // directed vectors
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle();
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'h1);

        issue(OP_MTHI, 32'd5, 32'd0, 1'b0);
        issue(OP_MTLO, 32'd7, 32'd0, 1'b0);
        issue(OP_MADD, 32'd2, 32'd3, 1'b0);
        wait_idle();
        check("madd_hi", hi, 32'd5);
        check("madd_lo", lo, 32'd13);
        issue(OP_MSUBU, 32'd1, 32'd14, 1'b0);
        wait_idle();
        check("msubu_hi", hi, 32'd4);
        check("msubu_lo", lo, 32'hFFFF_FFFF);

        issue(OP_MTLO, 32'h1234, 32'd0, 1'b0);
        issue(OP_DIV, 32'd99, 32'd0, 1'b0);
        wait_idle();
        check("div0_lo", lo, 32'h1234);
        check("div0_hi", hi, 32'd4);

        issue(OP_MTHI, 32'd9, 32'd0, 1'b1);
        wait_idle();
        check("flush_hi", hi, 32'd4);
        check("flush_busy", 32'(busy), 32'h0);

        issue(OP_MULT, 32'd3, 32'd4, 1'b0);
        idle(2);
        issue(OP_MTHI, 32'h55, 32'd0, 1'b0);
        wait_idle();
        check("inflight_hi", hi, 32'd0);
        check("inflight_lo", lo, 32'd12);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h1);

        // randomized traffic; short gaps land some starts inside busy windows
        for (int i = 0; i < 120; i++) begin
            issue(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
                  ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 12));
        end
        wait_idle();

        // reset in the 3rd busy cycle of a MULT
        issue(OP_MTHI, 32'hAAAA, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h5555, 32'd0, 1'b0);
        wait_idle();
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstbusy_busy", 32'(busy), 32'h0);
        check("rstbusy_hi", hi, 32'h0);
        check("rstbusy_lo", lo, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rstbusy_hold_lo", lo, 32'h0);
            check("rstbusy_hold_busy", 32'(busy), 32'h0);
        end
        m_acc      = '0;
        busy_until = edge_idx;

        issue(OP_MADDU, 32'd6, 32'd7, 1'b0);
        wait_idle();
        check("post_rst_lo", lo, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and HI/LO width.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for multiply-class ops; legal range 1..15.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for divide-class ops; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  qualifies op for one cycle; the unit accepts it only when busy=0 and flush=0.
REQ-007 op  in  4  operation code (REQ-012).
REQ-008 a  in  WIDTH  rs operand.
REQ-009 b  in  WIDTH  rt operand.
REQ-010 flush  in  1  exception/interrupt commit cancel; suppresses acceptance in the same cycle.
REQ-011 busy  out  1 / hi  out  WIDTH / lo  out  WIDTH; all three are registered.

Function
REQ-012 Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; codes 11-15 are reserved and have no effect.
REQ-013 FSM states: IDLE and BUSY; IDLE->BUSY on an accepted multiply- or divide-class op; BUSY->IDLE when the counter reaches 0.
REQ-014 Accept: the counter loads MULT_CYCLES (ops 1,2,7-10) or DIV_CYCLES (ops 3,4); busy=1 from the next cycle for exactly that many cycles.
REQ-015 The result is computed from a, b and current {hi,lo} at acceptance and held in pending registers; hi/lo update on the edge that returns busy to 0.
REQ-016 hi/lo keep their old values throughout busy.
REQ-017 MULT/MULTU: {hi,lo} = signed/unsigned 2*WIDTH-bit product.
REQ-018 MADD(U)/MSUB(U): {hi,lo} = {hi,lo} +/- product, signedness per op, modulo 2^(2*WIDTH).
REQ-019 DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend; DIVU unsigned.
REQ-020 DIV with a = most-negative and b = -1: lo = a, hi = 0.
REQ-021 Divide by zero (DIV/DIVU with b=0): busy sequence runs normally; hi/lo keep their prior values.
REQ-022 MTHI/MTLO, when accepted: hi (or lo) = a at that edge; no busy cycles.
REQ-023 NOP or a reserved op, when accepted: no state change.
REQ-024 start while busy=1: ignored; the in-flight op is unaffected.
REQ-025 flush=1: the same-cycle start is ignored, including MTHI/MTLO; an op already in BUSY completes normally (it was committed).
REQ-026 Counter width: 4 bits; no wrap; the unit decrements only in BUSY.

Reset
REQ-027 On reset: busy=0, hi=0, lo=0, counter=0, pending registers cleared, state IDLE.
REQ-028 Reset overrides start and flush in the same cycle.
REQ-029 Reset during BUSY discards the in-flight op; hi/lo are not written.

Structure
REQ-030 Package mdu_pkg holds the op-code constants, the op-class decode function and the default cycle constants.
REQ-031 One sub-module, mdu_div_core, is combinational and performs signed/unsigned divide with the REQ-019..021 sign and special-case fix-ups; the top contains FSM, counter, multiply/accumulate and registers.
REQ-032 Parameter legality is checked at elaboration; out-of-range values are a fatal error.

Verification
REQ-033 MULT a=0xFFFFFFFE, b=3, defaults -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
REQ-035 MTHI 5, MTLO 7, then MADD a=2, b=3 -> hi=5, lo=13 after 5 busy cycles; MSUBU a=1, b=14 -> hi=4, lo=0xFFFFFFFF.
REQ-036 DIV with b=0 after MTLO 0x1234 -> 10 busy cycles; lo stays 0x1234.
REQ-037 start+flush with MTHI 9 -> hi unchanged, busy=0; start during BUSY -> ignored, first result intact.
REQ-038 Reset asserted in the 3rd busy cycle of MULT -> next cycle busy=0, hi=lo=0; result never appears.
